// File: rtl/eth_bus_seq_if.sv
// Requester handshake plus Ethernet-controller host-bus signals for eth_bus_seq.
// The sequencer side uses the slave modport; requesters and the bus model use master.
interface eth_bus_seq_if;
  logic        req0, req1;
  logic        wr0, wr1;
  logic [15:0] cmd0, cmd1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [15:0] rdata;
  logic        busy;
  logic        csn, cmd, rdn, wrn;
  logic [15:0] sd_out;
  logic        sd_oe;
  logic [15:0] sd_in;

  modport master (
    output req0, req1, wr0, wr1, cmd0, cmd1, wdata0, wdata1, sd_in,
    input  ack0, ack1, rdata, busy, csn, cmd, rdn, wrn, sd_out, sd_oe
  );

  modport slave (
    input  req0, req1, wr0, wr1, cmd0, cmd1, wdata0, wdata1, sd_in,
    output ack0, ack1, rdata, busy, csn, cmd, rdn, wrn, sd_out, sd_oe
  );
endinterface

// File: rtl/eth_bus_seq.sv
// Two-requester round-robin sequencer driving an Ethernet controller host bus:
// address write phase, gap, data write/read phase, recovery, then a one-cycle ack.
module eth_bus_seq #(
  parameter int unsigned T_WR  = 2,
  parameter int unsigned T_GAP = 1,
  parameter int unsigned T_RD  = 2
) (
  input logic          clk40m,
  input logic          reset,
  eth_bus_seq_if.slave bus
);

  localparam int unsigned TMAX = (T_WR > T_GAP) ? ((T_WR > T_RD) ? T_WR : T_RD)
                                                : ((T_GAP > T_RD) ? T_GAP : T_RD);
  localparam int unsigned CW = $clog2(TMAX + 1);
  localparam logic [CW-1:0] WR_LAST  = CW'(T_WR - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(T_GAP - 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(T_RD - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR_WR, ADDR_GAP, DATA_WR, DATA_RD, RECOVER, DONE
  } state_t;

  state_t      state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic        gnt, gnt_d;
  logic        last_g, last_d;
  logic        load, cap;
  logic        lat_wr;
  logic [15:0] lat_cmd, lat_wdata, rdata_q;
  logic        csn, cmd_s, wrn, rdn, sd_oe, ack0, ack1;
  logic [15:0] sd_out;

  always_comb begin
    state_d = state;
    cnt_d   = cnt + 1'b1;
    gnt_d   = gnt;
    last_d  = last_g;
    load    = 1'b0;
    cap     = 1'b0;
    csn     = 1'b1;
    cmd_s   = 1'b0;
    wrn     = 1'b1;
    rdn     = 1'b1;
    sd_oe   = 1'b0;
    sd_out  = '0;
    ack0    = 1'b0;
    ack1    = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (bus.req0 || bus.req1) begin
          load    = 1'b1;
          gnt_d   = (bus.req0 && bus.req1) ? ~last_g : bus.req1;
          state_d = ADDR_WR;
        end
      end
      ADDR_WR: begin
        csn    = 1'b0;
        cmd_s  = 1'b1;
        wrn    = 1'b0;
        sd_oe  = 1'b1;
        sd_out = lat_cmd;
        if (cnt == WR_LAST) begin
          cnt_d   = '0;
          state_d = ADDR_GAP;
        end
      end
      ADDR_GAP: begin
        csn    = 1'b0;
        cmd_s  = 1'b1;
        sd_oe  = 1'b1;
        sd_out = lat_cmd;
        if (cnt == GAP_LAST) begin
          cnt_d   = '0;
          state_d = lat_wr ? DATA_WR : DATA_RD;
        end
      end
      DATA_WR: begin
        csn    = 1'b0;
        wrn    = 1'b0;
        sd_oe  = 1'b1;
        sd_out = lat_wdata;
        if (cnt == WR_LAST) begin
          cnt_d   = '0;
          state_d = RECOVER;
        end
      end
      DATA_RD: begin
        csn = 1'b0;
        rdn = 1'b0;
        if (cnt == RD_LAST) begin
          cap     = 1'b1;
          cnt_d   = '0;
          state_d = RECOVER;
        end
      end
      RECOVER: begin
        csn = 1'b0;
        if (cnt == GAP_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        cnt_d   = '0;
        ack0    = ~gnt;
        ack1    = gnt;
        last_d  = gnt;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // last_g=1 after reset so a simultaneous first request goes to requester 0
  always_ff @(posedge clk40m) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      gnt       <= 1'b0;
      last_g    <= 1'b1;
      lat_wr    <= 1'b0;
      lat_cmd   <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      gnt    <= gnt_d;
      last_g <= last_d;
      if (load) begin
        lat_wr    <= gnt_d ? bus.wr1    : bus.wr0;
        lat_cmd   <= gnt_d ? bus.cmd1   : bus.cmd0;
        lat_wdata <= gnt_d ? bus.wdata1 : bus.wdata0;
      end
      if (cap) rdata_q <= bus.sd_in;
    end
  end

  assign bus.csn    = csn;
  assign bus.cmd    = cmd_s;
  assign bus.wrn    = wrn;
  assign bus.rdn    = rdn;
  assign bus.sd_oe  = sd_oe;
  assign bus.sd_out = sd_out;
  assign bus.ack0   = ack0;
  assign bus.ack1   = ack1;
  assign bus.rdata  = rdata_q;
  assign bus.busy   = (state != IDLE);

endmodule

// File: tb/tb_eth_bus_seq.sv
// Self-checking bench for eth_bus_seq: default timing instance (a) and a
// T_WR=3/T_GAP=2/T_RD=4 instance (b), both checked against a cycle-offset model.
module tb_eth_bus_seq;
  logic clk40m = 1'b0;
  logic rst_a, rst_b;
  int   total = 0;
  int   bad   = 0;

  int          tw [2] = '{2, 3};
  int          tg [2] = '{1, 2};
  int          tr [2] = '{2, 4};
  bit          last_srv [2];
  logic [15:0] exp_rd [2];
  logic [15:0] bv [2];

  // vector layout: csn cmd wrn rdn sd_oe sd_out(masked by oe) ack0 ack1 busy
  localparam logic [23:0] IDLE_V = {5'b10110, 16'h0000, 3'b000};

  eth_bus_seq_if ifa ();
  eth_bus_seq_if ifb ();

  eth_bus_seq dut_a (.clk40m(clk40m), .reset(rst_a), .bus(ifa.slave));
  eth_bus_seq #(.T_WR(3), .T_GAP(2), .T_RD(4))
    dut_b (.clk40m(clk40m), .reset(rst_b), .bus(ifb.slave));

  // bus model: the read value is only visible while rdn is low
  assign ifa.sd_in = (ifa.rdn === 1'b0) ? bv[0] : ~bv[0];
  assign ifb.sd_in = (ifb.rdn === 1'b0) ? bv[1] : ~bv[1];

  always #12 clk40m = ~clk40m;

  function automatic logic [23:0] ref_vec(bit sel, bit wr, int k,
                                          logic [15:0] c, logic [15:0] d, bit g);
    int a1, a2, a3, a4;
    a1 = tw[sel];
    a2 = a1 + tg[sel];
    a3 = a2 + (wr ? tw[sel] : tr[sel]);
    a4 = a3 + tg[sel];
    if (k <= a1)      return {5'b01011, c, 3'b001};
    else if (k <= a2) return {5'b01111, c, 3'b001};
    else if (k <= a3) return wr ? {5'b00011, d, 3'b001} : {5'b00100, 16'h0000, 3'b001};
    else if (k <= a4) return {5'b00110, 16'h0000, 3'b001};
    else              return {5'b10110, 16'h0000, ~g, g, 1'b1};
  endfunction

  function automatic logic [23:0] obs(bit sel);
    if (sel)
      return {ifb.csn, ifb.cmd, ifb.wrn, ifb.rdn, ifb.sd_oe,
              ifb.sd_oe ? ifb.sd_out : 16'h0000, ifb.ack0, ifb.ack1, ifb.busy};
    return {ifa.csn, ifa.cmd, ifa.wrn, ifa.rdn, ifa.sd_oe,
            ifa.sd_oe ? ifa.sd_out : 16'h0000, ifa.ack0, ifa.ack1, ifa.busy};
  endfunction

  function automatic logic [15:0] rd_obs(bit sel);
    return sel ? ifb.rdata : ifa.rdata;
  endfunction

  task automatic check(string tag, logic [23:0] o, logic [23:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic set_req(bit sel, bit r, logic v, logic wr, logic [15:0] c, logic [15:0] d);
    case ({sel, r})
      2'b00: begin ifa.req0 = v; ifa.wr0 = wr; ifa.cmd0 = c; ifa.wdata0 = d; end
      2'b01: begin ifa.req1 = v; ifa.wr1 = wr; ifa.cmd1 = c; ifa.wdata1 = d; end
      2'b10: begin ifb.req0 = v; ifb.wr0 = wr; ifb.cmd0 = c; ifb.wdata0 = d; end
      default: begin ifb.req1 = v; ifb.wr1 = wr; ifb.cmd1 = c; ifb.wdata1 = d; end
    endcase
  endtask

  // Starts at the negedge of the IDLE cycle where the grant happens; ends at DONE negedge.
  task automatic follow(bit sel, bit g, bit wr, logic [15:0] c, logic [15:0] d,
                        logic [15:0] rv, bit corrupt);
    int len;
    len = 1 + tw[sel] + tg[sel] + (wr ? tw[sel] : tr[sel]) + tg[sel];
    bv[sel] = rv;
    for (int k = 1; k <= len; k++) begin
      @(posedge clk40m); @(negedge clk40m);
      check($sformatf("trace%0d_g%0d_k%0d", sel, g, k), obs(sel), ref_vec(sel, wr, k, c, d, g));
      if (corrupt && k == 2) set_req(sel, g, 1'b1, ~wr, 16'($urandom), 16'($urandom));
    end
    if (!wr) exp_rd[sel] = rv;
    check($sformatf("rdata%0d", sel), {8'h00, rd_obs(sel)}, {8'h00, exp_rd[sel]});
    last_srv[sel] = g;
  endtask

  task automatic run_txn(bit sel, bit r, bit wr, logic [15:0] c, logic [15:0] d,
                         logic [15:0] rv, bit corrupt);
    set_req(sel, r, 1'b1, wr, c, d);
    check("idle_pre", obs(sel), IDLE_V);
    follow(sel, r, wr, c, d, rv, corrupt);
    set_req(sel, r, 1'b0, wr, c, d);
    @(posedge clk40m); @(negedge clk40m);
    check("idle_post", obs(sel), IDLE_V);
  endtask

  always @(negedge clk40m) begin
    total++;
    assert (!(ifa.wrn === 1'b0 && ifa.rdn === 1'b0) && !(ifa.sd_oe === 1'b1 && ifa.rdn === 1'b0)
            && !(ifa.ack0 === 1'b1 && ifa.ack1 === 1'b1)) else begin
      bad++;
      $error("FAIL inv_a wrn=%b rdn=%b oe=%b ack=%b%b required no overlap",
             ifa.wrn, ifa.rdn, ifa.sd_oe, ifa.ack0, ifa.ack1);
    end
    total++;
    assert (!(ifb.wrn === 1'b0 && ifb.rdn === 1'b0) && !(ifb.sd_oe === 1'b1 && ifb.rdn === 1'b0)
            && !(ifb.ack0 === 1'b1 && ifb.ack1 === 1'b1)) else begin
      bad++;
      $error("FAIL inv_b wrn=%b rdn=%b oe=%b ack=%b%b required no overlap",
             ifb.wrn, ifb.rdn, ifb.sd_oe, ifb.ack0, ifb.ack1);
    end
  end

  initial begin
    logic [15:0] rc, rdw, rvv;
    bit rs, rr, rw, rcor, g;
    ifa.req0 = 0; ifa.req1 = 0; ifa.wr0 = 0; ifa.wr1 = 0;
    ifa.cmd0 = '0; ifa.cmd1 = '0; ifa.wdata0 = '0; ifa.wdata1 = '0;
    ifb.req0 = 0; ifb.req1 = 0; ifb.wr0 = 0; ifb.wr1 = 0;
    ifb.cmd0 = '0; ifb.cmd1 = '0; ifb.wdata0 = '0; ifb.wdata1 = '0;
    bv[0] = '0; bv[1] = '0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    last_srv[0] = 1'b1; last_srv[1] = 1'b1;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (2) @(posedge clk40m);
    @(negedge clk40m);
    check("reset_a", obs(0), IDLE_V);
    check("reset_b", obs(1), IDLE_V);
    check("reset_rdata_a", {8'h00, rd_obs(0)}, 24'h0);
    check("reset_rdata_b", {8'h00, rd_obs(1)}, 24'h0);
    rst_a = 1'b0; rst_b = 1'b0;

    // directed write and read, default timing
    run_txn(0, 0, 1, 16'h3010, 16'h89AB, 16'h0000, 0);
    run_txn(0, 1, 0, 16'h30C0, 16'h0000, 16'h8870, 0);
    // parameter sweep instance
    run_txn(1, 1, 0, 16'h30C0, 16'h0000, 16'h8870, 0);
    run_txn(1, 0, 1, 16'h3010, 16'h89AB, 16'h0000, 0);

    // contention straight after reset, both held for four services
    rst_a = 1'b1;
    @(posedge clk40m); @(negedge clk40m);
    rst_a = 1'b0; last_srv[0] = 1'b1; exp_rd[0] = '0;
    set_req(0, 0, 1'b1, 1'b1, 16'h1111, 16'hAAAA);
    set_req(0, 1, 1'b1, 1'b0, 16'h2222, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(posedge clk40m); @(negedge clk40m); end
      check("rr_idle", obs(0), IDLE_V);
      g = ~last_srv[0];
      if (g) follow(0, 1, 0, 16'h2222, 16'h0000, 16'h5A5A + 16'(i), 0);
      else   follow(0, 0, 1, 16'h1111, 16'hAAAA, 16'h0000, 0);
    end
    set_req(0, 0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    set_req(0, 1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk40m); @(negedge clk40m);
    check("rr_done_idle", obs(0), IDLE_V);

    // reset while in the data write phase aborts without an ack
    set_req(0, 0, 1'b1, 1'b1, 16'h1234, 16'h5678);
    for (int k = 1; k <= tw[0] + tg[0] + 1; k++) begin
      @(posedge clk40m); @(negedge clk40m);
      check($sformatf("abort_k%0d", k), obs(0), ref_vec(0, 1, k, 16'h1234, 16'h5678, 0));
    end
    rst_a = 1'b1;
    set_req(0, 0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk40m); @(negedge clk40m);
    check("rst_abort", obs(0), IDLE_V);
    rst_a = 1'b0; last_srv[0] = 1'b1; exp_rd[0] = '0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk40m); @(negedge clk40m);
      check("no_ack_after_abort", obs(0), IDLE_V);
    end
    run_txn(0, 0, 1, 16'h4321, 16'hFEDC, 16'h0000, 0);

    // random transactions on both instances, some with mid-transaction field changes
    for (int n = 0; n < 40; n++) begin
      rs   = 1'($urandom_range(0, 1));
      rr   = 1'($urandom_range(0, 1));
      rw   = 1'($urandom_range(0, 1));
      rcor = 1'($urandom_range(0, 1));
      rc   = 16'($urandom);
      rdw  = 16'($urandom);
      rvv  = 16'($urandom);
      run_txn(rs, rr, rw, rc, rdw, rvv, rcor);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
